// File: rtl/mc_sequencer.sv
// Microcode timing-state sequencer: steps a one-hot T1..Tn ring per instruction, handling
// waits with a timeout, aborts, interrupts at instruction boundaries and a halt/park state.
module mc_sequencer #(
  parameter int unsigned NSTATES = 5,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TMO_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         len,
  input  logic               done,
  input  logic               wait_req,
  input  logic               ready,
  input  logic               abort,
  input  logic               irq,
  input  logic               halt,
  output logic [NSTATES-1:0] T,
  output logic               stall,
  output logic               retire,
  output logic               irq_take,
  output logic               timeout,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt
);

  localparam logic [3:0]         LenMin = 4'd3;
  localparam logic [3:0]         LenMax = 4'(NSTATES);
  localparam logic [NSTATES-1:0] TFirst = NSTATES'(1);

  logic [NSTATES-1:0] t_q, t_d;
  logic               halted_q, halted_d;
  logic [3:0]         len_q, len_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0] t_idx;
  logic [3:0] len_clamped;
  logic       wait_hold;
  logic       tmo_max;
  logic       at_end;
  logic       abort_go;
  logic       boundary;
  logic       park;

  // 1-based index of the active timing state; 0 while parked.
  always_comb begin
    t_idx = '0;
    for (int i = 0; i < NSTATES; i++) begin
      if (t_q[i]) t_idx = 4'(i + 1);
    end
  end

  always_comb begin
    if ({1'b0, len} < LenMin) begin
      len_clamped = LenMin;
    end else if ({1'b0, len} > LenMax) begin
      len_clamped = LenMax;
    end else begin
      len_clamped = {1'b0, len};
    end
  end

  assign wait_hold = wait_req & ~ready;
  assign tmo_max   = &tmo_q;
  // done is only honoured from T3 onward; len_q is always >= 3 once loaded.
  assign at_end    = (t_idx >= LenMin) && ((t_idx == len_q) || done);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      t_q      <= TFirst;
      halted_q <= 1'b0;
      len_q    <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
      len_q    <= len_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output decode: priority abort > timeout > stall > end of instruction.
  always_comb begin
    abort_go = 1'b0;
    timeout  = 1'b0;
    stall    = 1'b0;
    retire   = 1'b0;
    if (!reset && !halted_q) begin
      if (abort) begin
        abort_go = 1'b1;
      end else if (wait_hold && tmo_max) begin
        timeout = 1'b1;
      end else if (wait_hold) begin
        stall = 1'b1;
      end else if (at_end) begin
        retire = 1'b1;
      end
    end
    irq_take = (retire & irq) | (halted_q & irq & ~reset);
  end

  assign boundary = abort_go | timeout | retire;
  // A pending interrupt always beats a halt request at a boundary.
  assign park     = boundary & halt & ~irq;

  // Next-state logic
  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    len_d    = len_q;
    tmo_d    = stall ? tmo_q + TMO_W'(1) : '0;
    cnt_d    = cnt_q + CNT_W'(retire);
    if (halted_q) begin
      if (!halt || irq) begin
        t_d      = TFirst;
        halted_d = 1'b0;
      end
    end else if (boundary) begin
      if (park) begin
        t_d      = '0;
        halted_d = 1'b1;
      end else begin
        t_d = TFirst;
      end
    end else if (!stall) begin
      t_d = {t_q[NSTATES-2:0], t_q[NSTATES-1]};
      if (t_q[1]) len_d = len_clamped;
    end
  end

  assign T           = t_q;
  assign halted      = halted_q;
  assign retired_cnt = cnt_q;

  assert property (@(posedge clk) disable iff (reset) $onehot0(t_q));
  assert property (@(posedge clk) disable iff (reset) halted_q == (t_q == '0));

endmodule

// File: tb/tb_mc_sequencer.sv
// Table-driven bench for mc_sequencer (NSTATES=5, CNT_W=4, TMO_W=2) with a scoreboard queue
// and a hand-written bounded wait for the timeout corner case.
module tb_mc_sequencer;

  logic       clk = 1'b0;
  logic       reset, done, wait_req, ready, abort, irq, halt;
  logic [2:0] len;
  logic [4:0] T;
  logic       stall, retire, irq_take, timeout, halted;
  logic [3:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  mc_sequencer #(
    .NSTATES(5),
    .CNT_W  (4),
    .TMO_W  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .len        (len),
    .done       (done),
    .wait_req   (wait_req),
    .ready      (ready),
    .abort      (abort),
    .irq        (irq),
    .halt       (halt),
    .T          (T),
    .stall      (stall),
    .retire     (retire),
    .irq_take   (irq_take),
    .timeout    (timeout),
    .halted     (halted),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [2:0] len;
    logic       dn, wr, rd, ab, iq, hl;
    logic       e_stall, e_ret, e_itk, e_tmo;
    logic [4:0] e_t;
    logic       e_h;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic r, logic [2:0] l, logic d, logic wr, logic rd, logic ab,
                              logic iq, logic hl, logic es, logic er, logic ei, logic et,
                              logic [4:0] t, logic h, logic [3:0] c);
    vec_t v;
    v = '{rst: r, len: l, dn: d, wr: wr, rd: rd, ab: ab, iq: iq, hl: hl,
          e_stall: es, e_ret: er, e_itk: ei, e_tmo: et, e_t: t, e_h: h, e_cnt: c};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; len = v.len; done = v.dn; wait_req = v.wr;
    ready = v.rd; abort = v.ab; irq = v.iq; halt = v.hl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] pulses;
    vec_t       e;
    int         cycles, stalls;
    logic       seen;

    reset = 1'b1; len = '0; done = 0; wait_req = 0; ready = 0; abort = 0; irq = 0; halt = 0;

    // Fields: rst len done wr rd abort irq halt | stall ret itk tmo | T halted cnt
    tbl.push_back(mk(1, 5, 1, 1, 0, 1, 1, 1,  0, 0, 0, 0,  1, 0, 0));
    // len=5 full pass
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 0));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 0));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  8, 0, 0));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 16, 0, 0));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 0, 1));
    // len=4, done held high: ignored in T1/T2, ends in T3
    tbl.push_back(mk(0, 4, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 1));
    tbl.push_back(mk(0, 4, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 1));
    tbl.push_back(mk(0, 4, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 0, 2));
    // len=1 clamps to 3
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 0, 3));
    // len=7 clamps to 5
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 3));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 3));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  8, 0, 3));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 16, 0, 3));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 0, 4));
    // wait in T4, ready on the 4th cycle
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 4));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 4));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  8, 0, 4));
    tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0,  8, 0, 4));
    tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0,  8, 0, 4));
    tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0,  8, 0, 4));
    tbl.push_back(mk(0, 5, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 16, 0, 4));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 0, 5));
    // timeout in T4 (limit 3): fires on the 4th waiting cycle
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 5));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 5));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  8, 0, 5));
    tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0,  8, 0, 5));
    tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0,  8, 0, 5));
    tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0,  8, 0, 5));
    tbl.push_back(mk(0, 5, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1,  1, 0, 5));
    // abort in T3 alongside wait, done and irq
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 5));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 5));
    tbl.push_back(mk(0, 5, 1, 1, 0, 1, 1, 0,  0, 0, 0, 0,  1, 0, 5));
    // halt at retire, parked, abort ignored, irq wakes
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 5));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 5));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0,  0, 1, 6));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 1, 6));
    tbl.push_back(mk(0, 3, 0, 1, 0, 1, 0, 1,  0, 0, 0, 0,  0, 1, 6));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1, 1,  0, 0, 1, 0,  1, 0, 6));
    // irq+halt: no effect mid-instruction, irq wins at retire
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0,  2, 0, 6));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0,  4, 0, 6));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 1, 1,  0, 1, 1, 0,  1, 0, 7));
    // abort with halt parks; halt release wakes without irq_take
    tbl.push_back(mk(0, 3, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0,  0, 1, 7));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 7));
    // nine more retires: counter wraps 15 -> 0
    for (int i = 0; i < 9; i++) begin
      tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 4'(7 + i)));
      tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 4'(7 + i)));
      tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 0, 4'(8 + i)));
    end
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  1, 0, 1));
    // reset in T4 mid-wait
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 1));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 1));
    tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  8, 0, 1));
    tbl.push_back(mk(1, 5, 1, 1, 0, 1, 1, 1,  0, 0, 0, 0,  1, 0, 0));
    // reset while parked
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  2, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0,  0, 1, 1));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      #1 pulses = {stall, retire, irq_take, timeout};
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d pulses", i), 32'(pulses), 32'({e.e_stall, e.e_ret, e.e_itk, e.e_tmo}));
      chk($sformatf("v%0d T", i), 32'(T), 32'(e.e_t));
      chk($sformatf("v%0d halted", i), 32'(halted), 32'(e.e_h));
      chk($sformatf("v%0d retired_cnt", i), 32'(retired_cnt), 32'(e.e_cnt));
    end

    // Hand-written: bounded wait for the timeout pulse from T4.
    @(negedge clk);
    reset = 1; len = 3'd5; done = 0; wait_req = 0; ready = 0; abort = 0; irq = 0; halt = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("hs T4 before wait", 32'(T), 32'd8);
    wait_req = 1;
    cycles = 0;
    stalls = 0;
    seen = 0;
    while (!seen && cycles < 12) begin
      @(negedge clk);
      #1;
      cycles++;
      if (stall) stalls++;
      if (timeout) seen = 1;
      @(posedge clk);
      #1;
    end
    chk("hs timeout seen", 32'(seen), 32'd1);
    chk("hs timeout cycle", 32'(cycles), 32'd4);
    chk("hs stall cycles", 32'(stalls), 32'd3);
    chk("hs T after timeout", 32'(T), 32'd1);
    chk("hs cnt after timeout", 32'(retired_cnt), 32'd0);
    wait_req = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
